// File: rtl/header_walk_seq.sv
// header_walk_seq: walks a single active pin across a header bus with dwell/gap timing; HEADER_WALK_LOOP_EN repeats passes.
module header_walk_seq #(
  parameter int NUM_PINS     = 37,
  parameter int DWELL_CYCLES = 50000,
  parameter int GAP_CYCLES   = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                invert,
  output logic [NUM_PINS-1:0] bus_out,
  output logic [5:0]          pin_idx,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;
`ifdef HEADER_WALK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam logic [31:0] DW   = 32'(DWELL_CYCLES - 1);
  localparam logic [31:0] GP   = 32'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [5:0]  LAST = 6'(NUM_PINS - 1);
  state_t state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [5:0] idx_n;
  logic inv, inv_n, adv, last;
  logic [NUM_PINS-1:0] bus_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pin_idx <= '0;
      inv     <= 1'b0;
      bus_out <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pin_idx <= idx_n;
      inv     <= inv_n;
      bus_out <= bus_n;
    end
  end
  // counter reloads with (length-1) on each state entry and expires at zero
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = pin_idx;
    inv_n   = inv;
    last    = pin_idx == LAST;
    adv     = cnt == 0 && (state == GAP || (state == DRIVE && GAP_CYCLES == 0));
    case (state)
      IDLE: if (start && !stop) begin
        state_n = DRIVE;
        cnt_n   = DW;
        idx_n   = '0;
        inv_n   = invert;
      end
      DRIVE: if (cnt != 0) cnt_n = cnt - 1;
        else if (GAP_CYCLES > 0) begin
          state_n = GAP;
          cnt_n   = GP;
        end
      GAP: if (cnt != 0) cnt_n = cnt - 1;
      DONE: begin
        state_n = LOOP ? DRIVE : IDLE;
        cnt_n   = LOOP ? DW : '0;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    if (adv) begin
      state_n = last ? DONE : DRIVE;
      cnt_n   = last ? '0 : DW;
      idx_n   = last ? pin_idx : pin_idx + 6'd1;
    end
    if (stop && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end
  end
  always_comb begin
    busy  = state != IDLE;
    done  = state == DONE;
    bus_n = state_n == IDLE ? '0 :
            state_n == DRIVE ? (NUM_PINS'(1) << idx_n) ^ {NUM_PINS{inv_n}} : {NUM_PINS{inv_n}};
  end
endmodule
